// File: rtl/pipe_stage_buffer_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer_pkg
// Shared definitions for the pipeline stage buffers.
//   - Payload widths of the four classic stage boundaries (IF/ID, ID/EX,
//     EX/MEM, MEM/WB) and their NOP/bubble encodings. A bubble is all zero, so
//     every control bit inside it means "no write / no side effect".
//   - Small helpers shared by the buffer implementation.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_stage_buffer_pkg;

    typedef enum logic [1:0] {
        STAGE_IF_ID  = 2'd0,
        STAGE_ID_EX  = 2'd1,
        STAGE_EX_MEM = 2'd2,
        STAGE_MEM_WB = 2'd3
    } stage_e;

    localparam int IF_ID_W  = 32;
    localparam int ID_EX_W  = 82;
    localparam int EX_MEM_W = 40;
    localparam int MEM_WB_W = 54;

    localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = '0;
    localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = '0;
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = '0;

    // Payload width of a given stage boundary, for parameterising instances.
    function automatic int stage_width(input stage_e stage);
        case (stage)
            STAGE_IF_ID:  return IF_ID_W;
            STAGE_ID_EX:  return ID_EX_W;
            STAGE_EX_MEM: return EX_MEM_W;
            default:      return MEM_WB_W;
        endcase
    endfunction

    // Number of held entries from the two valid bits.
    function automatic logic [1:0] entry_count(input logic main_valid,
                                               input logic skid_valid);
        return {1'b0, main_valid} + {1'b0, skid_valid};
    endfunction

endpackage

// File: rtl/pipe_stage_buffer_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
// One valid+data register slot. Used as the main register and, when present,
// as the skid register of pipe_stage_buffer.
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset (loads BUBBLE, clears valid)
//   clear       synchronous clear (flush); beats load
//   load        update the slot this cycle
//   load_valid  valid bit to store on load
//   load_data   payload to store on load (only taken when load_valid=1)
//   valid       stored valid bit
//   data        stored payload
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_stage_buffer_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;

    // Emptying the slot keeps the old payload; it is don't-care once invalid,
    // and leaving it alone avoids toggling the wide data bus.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            data_d  = BUBBLE;
        end else if (load) begin
            valid_d = load_valid;
            if (load_valid) begin
                data_d = load_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer
// Valid/ready pipeline stage register with optional skid entry, flush to a
// bubble, and a saturating downstream-stall counter.
// Parameters:
//   WIDTH   payload width (1..256)
//   SKID    1 = two-entry skid buffer, registered in_ready
//           0 = single register, in_ready combinational from out_ready
//   BUBBLE  payload loaded on reset and flush
//   CNT_W   stall counter width
// Ports:
//   clock, reset (async active-low), flush (sync squash of all entries)
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake
//   stall_count                   cycles with out_valid && !out_ready (sat.)
//   occupancy                     entries currently held
// -----------------------------------------------------------------------------
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       occupancy
);

    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             main_load;
    logic             main_load_valid;
    logic [WIDTH-1:0] main_load_data;
    logic             skid_valid;
    logic             xfer_in;

    assign xfer_in = in_valid && in_ready;

    pipe_skid_reg #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clock      (clock),
        .reset      (reset),
        .clear      (flush),
        .load       (main_load),
        .load_valid (main_load_valid),
        .load_data  (main_load_data),
        .valid      (main_valid),
        .data       (main_data)
    );

    generate
        if (SKID) begin : gen_skid
            logic             main_can_load;
            logic             skid_load;
            logic             skid_load_valid;
            logic [WIDTH-1:0] skid_data;

            // in_ready depends only on the skid flop, so no combinational
            // path runs from out_ready back to the upstream stage.
            assign in_ready      = !skid_valid;
            assign main_can_load = !main_valid || out_ready;

            // Main refills from skid first so the older entry leaves first.
            // While skid is full in_ready is low, so skid and a new input
            // never compete for the main register in the same cycle.
            always_comb begin
                main_load       = main_can_load;
                main_load_valid = skid_valid || xfer_in;
                main_load_data  = skid_valid ? skid_data : in_data;
            end

            // Skid empties when main drains it, fills when main is stuck.
            always_comb begin
                skid_load       = (main_can_load && skid_valid) ||
                                  (!main_can_load && xfer_in);
                skid_load_valid = !main_can_load;
            end

            pipe_skid_reg #(
                .WIDTH  (WIDTH),
                .BUBBLE (BUBBLE)
            ) u_skid (
                .clock      (clock),
                .reset      (reset),
                .clear      (flush),
                .load       (skid_load),
                .load_valid (skid_load_valid),
                .load_data  (in_data),
                .valid      (skid_valid),
                .data       (skid_data)
            );
        end else begin : gen_single
            assign skid_valid = 1'b0;
            assign in_ready   = !main_valid || out_ready;

            // A consuming downstream with no new input leaves the slot empty.
            always_comb begin
                main_load       = xfer_in || (main_valid && out_ready);
                main_load_valid = xfer_in;
                main_load_data  = in_data;
            end
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = entry_count(main_valid, skid_valid);

    // Stall counter keeps counting through flush; only reset clears it.
    logic [CNT_W-1:0] stall_count_d, stall_count_q;

    always_comb begin
        stall_count_d = stall_count_q;
        if (main_valid && !out_ready && (stall_count_q != STALL_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buffer
// Drives two buffer instances: A (SKID=1, WIDTH=16, CNT_W=4) and
// B (SKID=0, WIDTH=16, CNT_W=16). Accepted payloads are queued as they are
// driven; a negedge monitor per instance pops and compares on each output
// transfer.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [15:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid;
    logic [15:0] a_out_data;
    logic [3:0]  a_stall;
    logic [1:0]  a_occ;

    logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [15:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [15:0] b_out_data;
    logic [15:0] b_stall;
    logic [1:0]  b_occ;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          b_pops = 0;
    logic [15:0] a_q[$];
    logic [15:0] b_q[$];

    initial forever #5 clock = ~clock;

    pipe_stage_buffer #(.WIDTH(16), .SKID(1'b1), .BUBBLE(16'h0000), .CNT_W(4)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .flush       (a_flush),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_data     (a_in_data),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_data    (a_out_data),
        .stall_count (a_stall),
        .occupancy   (a_occ)
    );

    pipe_stage_buffer #(.WIDTH(16), .SKID(1'b0), .BUBBLE(16'h0000), .CNT_W(16)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .flush       (b_flush),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_data     (b_in_data),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_data    (b_out_data),
        .stall_count (b_stall),
        .occupancy   (b_occ)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one instance's inputs; queue the payload when the bench expects it accepted.
    task automatic applyStimulus(input bit sel_b, input logic vld, input logic [15:0] dat,
                                 input logic rdy, input logic flsh, input bit accept);
        if (!sel_b) begin
            a_in_valid  = vld;
            a_in_data   = dat;
            a_out_ready = rdy;
            a_flush     = flsh;
            if (accept) a_q.push_back(dat);
        end else begin
            b_in_valid  = vld;
            b_in_data   = dat;
            b_out_ready = rdy;
            b_flush     = flsh;
            if (accept) b_q.push_back(dat);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Output-side scoreboard for instance A.
    always @(negedge clock) begin
        if (reset && !a_flush && a_out_valid && a_out_ready) begin
            checkOutput("a_out_expected", 32'(a_q.size() != 0), 32'd1);
            if (a_q.size() != 0) checkOutput("a_out_order", 32'(a_out_data), 32'(a_q.pop_front()));
        end
    end

    // Output-side scoreboard for instance B.
    always @(negedge clock) begin
        if (reset && !b_flush && b_out_valid && b_out_ready) begin
            checkOutput("b_out_expected", 32'(b_q.size() != 0), 32'd1);
            if (b_q.size() != 0) checkOutput("b_out_order", 32'(b_out_data), 32'(b_q.pop_front()));
            b_pops++;
        end
    end

    initial begin
        bit   exp_valid;
        bit   exp_ready;
        bit   rdy;
        int   sent;
        int   exp_stall;

        // Power-on reset
        #1 reset = 1'b0;
        #1;
        checkOutput("por_a_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("por_a_in_ready",  32'(a_in_ready),  32'd1);
        checkOutput("por_a_out_data",  32'(a_out_data),  32'd0);
        checkOutput("por_b_in_ready",  32'(b_in_ready),  32'd1);
        checkOutput("por_b_occ",       32'(b_occ),       32'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Streaming through the skid buffer
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1'b1, 16'(i), 1'b1, 1'b0, 1);
            @(negedge clock);
            checkOutput("stream_in_ready", 32'(a_in_ready), 32'd1);
            if (i > 1) begin
                checkOutput("stream_out_valid", 32'(a_out_valid), 32'd1);
                checkOutput("stream_out_data",  32'(a_out_data),  32'(i - 1));
            end
            nextCycle();
        end
        applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 0);
        @(negedge clock);
        checkOutput("stream_last_data", 32'(a_out_data), 32'h8);
        nextCycle();
        @(negedge clock);
        checkOutput("stream_drained", 32'(a_out_valid), 32'd0);
        checkOutput("stream_stall",   32'(a_stall),     32'd0);
        nextCycle();

        // Backpressure fills main then skid
        applyStimulus(0, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1);
        @(negedge clock);
        checkOutput("bp1_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("bp1_occ",      32'(a_occ),      32'd0);
        nextCycle();
        applyStimulus(0, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1);
        @(negedge clock);
        checkOutput("bp2_occ",      32'(a_occ),      32'd1);
        checkOutput("bp2_out_data", 32'(a_out_data), 32'hA5A5);
        nextCycle();
        applyStimulus(0, 1'b1, 16'h1234, 1'b0, 1'b0, 0);
        @(negedge clock);
        checkOutput("bp3_occ",      32'(a_occ),      32'd2);
        checkOutput("bp3_in_ready", 32'(a_in_ready), 32'd0);
        checkOutput("bp3_stall",    32'(a_stall),    32'd1);
        nextCycle();
        @(negedge clock);
        checkOutput("bp4_in_ready", 32'(a_in_ready), 32'd0);
        checkOutput("bp4_hold",     32'(a_out_data), 32'hA5A5);
        checkOutput("bp4_stall",    32'(a_stall),    32'd2);
        nextCycle();
        applyStimulus(0, 1'b1, 16'h1234, 1'b1, 1'b0, 0);
        @(negedge clock);
        checkOutput("bp5_in_ready", 32'(a_in_ready), 32'd0);
        nextCycle();
        applyStimulus(0, 1'b1, 16'h1234, 1'b1, 1'b0, 1);
        @(negedge clock);
        checkOutput("bp6_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("bp6_out_data", 32'(a_out_data), 32'h5A5A);
        checkOutput("bp6_occ",      32'(a_occ),      32'd1);
        nextCycle();
        applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 0);
        @(negedge clock);
        checkOutput("bp7_out_data", 32'(a_out_data), 32'h1234);
        nextCycle();
        @(negedge clock);
        checkOutput("bp8_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("bp8_stall",     32'(a_stall),     32'd3);
        nextCycle();

        // Flush with both entries full and a payload presented
        applyStimulus(0, 1'b1, 16'h1111, 1'b0, 1'b0, 1);
        nextCycle();
        applyStimulus(0, 1'b1, 16'h2222, 1'b0, 1'b0, 1);
        nextCycle();
        applyStimulus(0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 0);
        a_q.delete();
        @(negedge clock);
        checkOutput("fl_pre_occ", 32'(a_occ), 32'd2);
        nextCycle();
        applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 0);
        @(negedge clock);
        checkOutput("fl_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("fl_occ",       32'(a_occ),       32'd0);
        checkOutput("fl_out_data",  32'(a_out_data),  32'd0);
        checkOutput("fl_in_ready",  32'(a_in_ready),  32'd1);
        checkOutput("fl_stall",     32'(a_stall),     32'd5);
        nextCycle();
        @(negedge clock);
        checkOutput("fl_no_beef", 32'(a_out_valid), 32'd0);
        nextCycle();

        // Asynchronous reset mid-stream with two entries held
        applyStimulus(0, 1'b1, 16'h3333, 1'b0, 1'b0, 1);
        nextCycle();
        applyStimulus(0, 1'b1, 16'h4444, 1'b0, 1'b0, 1);
        nextCycle();
        applyStimulus(0, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        @(negedge clock);
        checkOutput("rst_pre_occ", 32'(a_occ), 32'd2);
        #2 reset = 1'b0;
        a_q.delete();
        #1;
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_occ",       32'(a_occ),       32'd0);
        checkOutput("rst_stall",     32'(a_stall),     32'd0);
        checkOutput("rst_out_data",  32'(a_out_data),  32'd0);
        checkOutput("rst_in_ready",  32'(a_in_ready),  32'd1);
        @(posedge clock);
        #1 reset = 1'b1;

        // Stall counter saturation at 4 bits
        applyStimulus(0, 1'b1, 16'h7777, 1'b0, 1'b0, 1);
        nextCycle();
        applyStimulus(0, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clock);
            checkOutput("sat_stall", 32'(a_stall), 32'((k < 15) ? k : 15));
            nextCycle();
        end
        checkOutput("sat_hold_data", 32'(a_out_data), 32'h7777);
        applyStimulus(0, 1'b0, 16'h0, 1'b1, 1'b0, 0);
        nextCycle();
        nextCycle();
        checkOutput("a_queue_empty", 32'(a_q.size()), 32'd0);

        // Single-register mode with out_ready toggling
        exp_valid = 1'b0;
        exp_stall = 0;
        sent      = 0;
        for (int k = 0; k < 100 && sent < 20; k++) begin
            rdy       = (k % 2) == 0;
            exp_ready = !exp_valid || rdy;
            applyStimulus(1, 1'b1, 16'(16'h0100 + sent), rdy, 1'b0, exp_ready);
            @(negedge clock);
            checkOutput("s0_in_ready",  32'(b_in_ready),  32'(exp_ready));
            checkOutput("s0_out_valid", 32'(b_out_valid), 32'(exp_valid));
            if (exp_valid && !rdy) exp_stall++;
            if (exp_ready) begin
                exp_valid = 1'b1;
                sent++;
            end
            nextCycle();
        end
        applyStimulus(1, 1'b0, 16'h0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 3; k++) nextCycle();
        checkOutput("s0_pops",        32'(b_pops),     32'd20);
        checkOutput("s0_queue_empty", 32'(b_q.size()), 32'd0);
        checkOutput("s0_stall",       32'(b_stall),    32'(exp_stall));
        checkOutput("s0_drained",     32'(b_out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised pipeline stage register. It is the next generation of the fixed-width hold/flush stage buffers placed between IF/ID, ID/EX, EX/MEM and MEM/WB. It replaces the ad-hoc hold input with a valid/ready handshake and adds an optional skid register, so a stalled downstream stage backpressures without a combinational ready path. It inserts a bubble (all-zero NOP) on flush and counts downstream stall cycles for performance debug.

Parameters:
WIDTH, 32, payload width in bits (1..256)
SKID, 1, 1 = two-entry skid buffer (registered in_ready, full throughput); 0 = single register (in_ready combinational from out_ready)
BUBBLE, {WIDTH{1'b0}}, payload value loaded on flush and reset (encodes NOP/no-write controls)
CNT_W, 16, width of stall counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  synchronous flush; squashes all held entries
in_valid  in  1  upstream presents payload
in_ready  out  1  stage accepts payload this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  payload held for downstream
out_ready  in  1  downstream consumes this cycle
out_data  out  WIDTH  payload to downstream
stall_count  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0
occupancy  out  2  entries held (0..2 when SKID=1, 0..1 when SKID=0)

Behaviour:
- Reset (reset=0, asynchronous): main_valid=0, skid_valid=0, out_data=BUBBLE, skid data=BUBBLE, stall_count=0, occupancy=0. in_ready is 1 after reset in both modes.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready. Payload latency is 1 cycle from input transfer to out_valid.
- SKID=1:
  - in_ready = !skid_valid (registered, no path from out_ready).
  - Main register can load when !main_valid || out_ready.
  - When the main register can load: if skid_valid, main takes the skid contents and skid_valid goes to 0. Otherwise, if an input transfer occurs, main takes in_data. Otherwise main_valid goes to 0.
  - When the main register cannot load (main_valid && !out_ready) and an input transfer occurs, the skid register captures in_data and skid_valid goes to 1.
  - Throughput is 1 transfer/cycle while out_ready=1. Full is 2 entries; in_ready=0 while skid is full.
- SKID=0:
  - in_ready = !main_valid || out_ready (combinational).
  - On an input transfer, main takes in_data. On an output transfer with no input transfer, main_valid goes to 0.
  - The skid register is not instantiated.
- flush=1 at an edge:
  - main_valid and skid_valid go to 0; out_data and skid data go to BUBBLE.
  - flush has priority over any simultaneous input or output transfer. A payload presented in the flush cycle is dropped, even though in_ready may read 1.
  - in_ready is 1 on the cycle after flush.
- Hold semantics: downstream holds the stage by driving out_ready=0. out_data and out_valid must remain stable while out_valid=1 and out_ready=0 (no payload change without a transfer).
- Ordering: payloads leave in arrival order. The skid entry always precedes any new input.
- stall_count:
  - +1 per cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Not cleared by flush; cleared only by reset.
- occupancy = main_valid + skid_valid.
- When out_valid=0, out_data must equal BUBBLE after reset or flush. After a normal drain, out_data keeps the last value and is don't-care.

Decomposition:
- Shared package: NOP/BUBBLE encodings per stage (IF/ID, ID/EX, EX/MEM, MEM/WB payload widths 32/82/40/54) and their zero-default constants.
- One sub-module is natural: pipe_skid_reg (single valid+data register with load enable and synchronous clear), instantiated once (SKID=0) or twice (SKID=1).

Test Plan:
1. Reset with reset=0 mid-stream while 2 entries are held -> out_valid=0, occupancy=0, stall_count=0, out_data=0, in_ready=1 immediately, without waiting for a clock edge.
2. Streaming, SKID=1, WIDTH=16: out_ready=1, inject 0x0001..0x0008 back-to-back -> out_data 0x0001..0x0008 on consecutive cycles starting 1 cycle later, in_ready constant 1, stall_count=0.
3. Backpressure, SKID=1:
   - Send 0xA5A5, 0x5A5A, 0x1234 with out_ready=0 -> occupancy 1 then 2; in_ready=0 on the cycle 0x1234 is presented, so 0x1234 is not accepted until the skid drains.
   - Release out_ready -> outputs 0xA5A5, 0x5A5A, 0x1234 in order.
   - stall_count = number of out_ready=0 cycles with out_valid=1.
4. Flush with both entries full and in_valid=1 carrying 0xBEEF -> next cycle out_valid=0, occupancy=0, out_data=BUBBLE, 0xBEEF never appears on the output.
5. SKID=0, out_ready toggling 1/0 each cycle with continuous in_valid -> in_ready follows out_ready combinationally when full, no payload lost or duplicated over 20 words.
6. Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_count reaches 15 and stays at 15.
